mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 23 ++
 rtl/mem_arbiter.sv | 127 ++++++++++++
 tb/tb_mem_arbiter.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the data-memory path: port identifiers,
// dm_ctrl access codes and the memory command bundle.
package mem_arbiter_pkg;

    typedef enum logic {
        PORT_C = 1'b0,
        PORT_D = 1'b1
    } port_e;

    localparam logic [2:0] DM_LB  = 3'b000;
    localparam logic [2:0] DM_LH  = 3'b001;
    localparam logic [2:0] DM_LW  = 3'b010;
    localparam logic [2:0] DM_LBU = 3'b100;
    localparam logic [2:0] DM_LHU = 3'b101;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  ctrl;
    } mem_cmd_t;

endpackage

// File: rtl/mem_arbiter.sv
// Two-port data-memory arbiter: round-robin between CPU (C) and
// loader/DMA (D), with a bounded D burst lock and 1-cycle read return.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned LOCK_MAX = 8
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        c_req,
    input  logic        c_we,
    input  logic [31:0] c_addr,
    input  logic [31:0] c_wdata,
    input  logic [2:0]  c_ctrl,
    output logic        c_gnt,
    output logic        c_rvalid,
    output logic [31:0] c_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic        d_lock,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [2:0]  d_ctrl,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [2:0]  m_ctrl,
    input  logic [31:0] m_rdata
);

    localparam int CW = $clog2(LOCK_MAX + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(LOCK_MAX);

    port_e         last_win_q, last_win_d;
    logic          locked_q, locked_d;
    logic [CW-1:0] lock_cnt_q, lock_cnt_d;
    logic          c_rvalid_q, c_rvalid_d;
    logic          d_rvalid_q, d_rvalid_d;
    logic [31:0]   c_rdata_q, c_rdata_d;
    logic [31:0]   d_rdata_q, d_rdata_d;

    logic     lock_hold;
    logic     sel_c, sel_d;
    mem_cmd_t cmd;

    // D keeps the bus through a locked burst until C has waited LOCK_MAX times
    assign lock_hold = (last_win_q == PORT_D) && locked_q && d_req
                       && !((lock_cnt_q == CNT_MAX) && c_req);
    assign sel_d = rstn && d_req
                   && (!c_req || (last_win_q == PORT_C) || lock_hold);
    assign sel_c = rstn && c_req && !sel_d;

    assign c_gnt = sel_c;
    assign d_gnt = sel_d;

    always_comb begin
        cmd = '0;
        unique case (1'b1)
            sel_c: cmd = '{we: c_we, addr: c_addr,
                           wdata: c_wdata, ctrl: c_ctrl};
            sel_d: cmd = '{we: d_we, addr: d_addr,
                           wdata: d_wdata, ctrl: d_ctrl};
            default: cmd = '0;
        endcase
    end

    assign m_we    = cmd.we;
    assign m_addr  = cmd.addr;
    assign m_wdata = cmd.wdata;
    assign m_ctrl  = cmd.ctrl;

    always_comb begin
        last_win_d = last_win_q;
        locked_d   = locked_q;
        lock_cnt_d = '0;
        c_rvalid_d = sel_c && !c_we;
        d_rvalid_d = sel_d && !d_we;
        c_rdata_d  = c_rdata_q;
        d_rdata_d  = d_rdata_q;
        if (sel_c) begin
            last_win_d = PORT_C;
        end
        if (sel_d) begin
            last_win_d = PORT_D;
            locked_d   = d_lock;
            if (d_lock) begin
                if (!c_req)
                    lock_cnt_d = lock_cnt_q;
                else if (lock_cnt_q == CNT_MAX)
                    lock_cnt_d = lock_cnt_q;
                else
                    lock_cnt_d = lock_cnt_q + CW'(1);
            end
        end
        if (c_rvalid_d) c_rdata_d = m_rdata;
        if (d_rvalid_d) d_rdata_d = m_rdata;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            last_win_q <= PORT_D;
            locked_q   <= 1'b0;
            lock_cnt_q <= '0;
            c_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
            c_rdata_q  <= '0;
            d_rdata_q  <= '0;
        end else begin
            last_win_q <= last_win_d;
            locked_q   <= locked_d;
            lock_cnt_q <= lock_cnt_d;
            c_rvalid_q <= c_rvalid_d;
            d_rvalid_q <= d_rvalid_d;
            c_rdata_q  <= c_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    assign c_rvalid = c_rvalid_q;
    assign d_rvalid = d_rvalid_q;
    assign c_rdata  = c_rdata_q;
    assign d_rdata  = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table with a read-return
// scoreboard, plus hand-written reset sequences.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int G_N = 0;
    localparam int G_C = 1;
    localparam int G_D = 2;
    localparam logic [2:0] CCTL = DM_LW;
    localparam logic [2:0] DCTL = DM_LHU;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        c_req = 0, c_we = 0;
    logic [31:0] c_addr = '0, c_wdata = '0;
    logic [2:0]  c_ctrl = '0;
    logic        c_gnt, c_rvalid;
    logic [31:0] c_rdata;
    logic        d_req = 0, d_we = 0, d_lock = 0;
    logic [31:0] d_addr = '0, d_wdata = '0;
    logic [2:0]  d_ctrl = '0;
    logic        d_gnt, d_rvalid;
    logic [31:0] d_rdata;
    logic        m_we;
    logic [31:0] m_addr, m_wdata;
    logic [2:0]  m_ctrl;
    logic [31:0] m_rdata;

    always #5 clk = ~clk;

    mem_arbiter #(.LOCK_MAX(8)) dut (
        .clk(clk), .rstn(rstn),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr),
        .c_wdata(c_wdata), .c_ctrl(c_ctrl),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
        .d_req(d_req), .d_we(d_we), .d_lock(d_lock), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_ctrl(d_ctrl),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_ctrl(m_ctrl), .m_rdata(m_rdata)
    );

    // data memory: unwritten words return an address-derived pattern
    logic [31:0] mem [0:255];
    bit          mem_wr [0:255];
    logic [31:0] shadow [0:255];
    bit          sh_wr [0:255];

    function automatic logic [31:0] dflt(input logic [7:0] i);
        return 32'hA5A5_0000 | {22'd0, i, 2'b00};
    endfunction

    assign m_rdata = mem_wr[m_addr[9:2]] ? mem[m_addr[9:2]]
                                         : dflt(m_addr[9:2]);

    always @(posedge clk) begin
        if (m_we) begin
            mem[m_addr[9:2]]    <= m_wdata;
            mem_wr[m_addr[9:2]] <= 1'b1;
        end
    end

    function automatic logic [31:0] exp_rd(input logic [31:0] a);
        return sh_wr[a[9:2]] ? shadow[a[9:2]] : dflt(a[9:2]);
    endfunction

    typedef struct {
        bit          c_req, c_we;
        logic [31:0] c_addr, c_wdata;
        bit          d_req, d_we, d_lock;
        logic [31:0] d_addr, d_wdata;
        int          eg;
    } vec_t;

    function automatic vec_t mk(
        input bit cr, input bit cw, input logic [31:0] ca,
        input logic [31:0] cd, input bit dr, input bit dw,
        input bit dl, input logic [31:0] da, input logic [31:0] dd,
        input int eg);
        vec_t r;
        r.c_req = cr; r.c_we = cw; r.c_addr = ca; r.c_wdata = cd;
        r.d_req = dr; r.d_we = dw; r.d_lock = dl;
        r.d_addr = da; r.d_wdata = dd; r.eg = eg;
        return r;
    endfunction

    int          tests = 0;
    int          fails = 0;
    logic [31:0] cq[$], dq[$];
    logic [31:0] c_last = '0, d_last = '0;
    vec_t        tbl[$];

    task automatic chk(input string n, input logic [31:0] a,
                       input logic [31:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
        end
    endtask

    task automatic ret_chk();
        logic [31:0] e;
        chk("c_rvalid", 32'(c_rvalid), 32'(cq.size() != 0));
        if (cq.size() != 0) begin
            e = cq.pop_front();
            chk("c_rdata", c_rdata, e);
            c_last = e;
        end else begin
            chk("c_rdata_hold", c_rdata, c_last);
        end
        chk("d_rvalid", 32'(d_rvalid), 32'(dq.size() != 0));
        if (dq.size() != 0) begin
            e = dq.pop_front();
            chk("d_rdata", d_rdata, e);
            d_last = e;
        end else begin
            chk("d_rdata_hold", d_rdata, d_last);
        end
    endtask

    task automatic step(input vec_t x);
        logic        ewe;
        logic [31:0] ea, ed;
        logic [2:0]  ec;
        c_req = x.c_req; c_we = x.c_we;
        c_addr = x.c_addr; c_wdata = x.c_wdata; c_ctrl = CCTL;
        d_req = x.d_req; d_we = x.d_we; d_lock = x.d_lock;
        d_addr = x.d_addr; d_wdata = x.d_wdata; d_ctrl = DCTL;
        #1;
        chk("c_gnt", 32'(c_gnt), 32'(x.eg == G_C));
        chk("d_gnt", 32'(d_gnt), 32'(x.eg == G_D));
        ewe = 0; ea = '0; ed = '0; ec = '0;
        if (x.eg == G_C) begin
            ewe = x.c_we; ea = x.c_addr; ed = x.c_wdata; ec = CCTL;
        end else if (x.eg == G_D) begin
            ewe = x.d_we; ea = x.d_addr; ed = x.d_wdata; ec = DCTL;
        end
        chk("m_we", 32'(m_we), 32'(ewe));
        chk("m_addr", m_addr, ea);
        chk("m_wdata", m_wdata, ed);
        chk("m_ctrl", 32'(m_ctrl), 32'(ec));
        if (x.eg == G_C) begin
            if (x.c_we) begin
                shadow[ea[9:2]] = ed; sh_wr[ea[9:2]] = 1'b1;
            end else cq.push_back(exp_rd(ea));
        end else if (x.eg == G_D) begin
            if (x.d_we) begin
                shadow[ea[9:2]] = ed; sh_wr[ea[9:2]] = 1'b1;
            end else dq.push_back(exp_rd(ea));
        end
        @(posedge clk);
        #1;
        ret_chk();
    endtask

    function automatic vec_t idle();
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, G_N);
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // simultaneous reads, then round-robin alternation
        tbl.push_back(mk(1, 0, 32'h10, 0, 1, 0, 0, 32'h20, 0, G_C));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 32'h20, 0, G_D));
        tbl.push_back(idle());
        for (int i = 0; i < 6; i++)
            tbl.push_back(mk(1, 0, 32'h100 + 32'(4 * i), 0, 1, 0, 0,
                             32'h200 + 32'(4 * i), 0,
                             (i % 2 == 0) ? G_C : G_D));
        tbl.push_back(idle());
        // D write then C read-back
        tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 32'h40, 32'hDEADBEEF, G_D));
        tbl.push_back(mk(1, 0, 32'h40, 0, 0, 0, 0, 0, 0, G_C));
        tbl.push_back(idle());
        // back-to-back C reads, then rdata hold
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(1, 0, 32'h44 + 32'(4 * i), 0,
                             0, 0, 0, 0, 0, G_C));
        tbl.push_back(idle());
        tbl.push_back(idle());
        // d_lock without d_req is ignored
        tbl.push_back(mk(1, 0, 32'h50, 0, 0, 0, 1, 32'h54, 0, G_C));
        tbl.push_back(idle());
        // locked D burst: 1 alone + 8 contended, then C once, D resumes
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 1, 32'h300, 0, G_D));
        for (int i = 0; i < 8; i++)
            tbl.push_back(mk(1, 0, 32'h80, 0, 1, 0, 1,
                             32'h304 + 32'(4 * i), 0, G_D));
        tbl.push_back(mk(1, 0, 32'h80, 0, 1, 0, 1, 32'h324, 0, G_C));
        tbl.push_back(mk(1, 0, 32'h84, 0, 1, 0, 1, 32'h324, 0, G_D));
        tbl.push_back(mk(1, 0, 32'h84, 0, 1, 0, 1, 32'h328, 0, G_D));
        tbl.push_back(idle());

        // reset state with requests present
        c_req = 1; d_req = 1; c_addr = 32'h10; d_addr = 32'h20;
        c_ctrl = CCTL; d_ctrl = DCTL;
        #2;
        chk("rst_c_gnt", 32'(c_gnt), 0);
        chk("rst_d_gnt", 32'(d_gnt), 0);
        chk("rst_m_we", 32'(m_we), 0);
        chk("rst_m_addr", m_addr, 0);
        chk("rst_m_ctrl", 32'(m_ctrl), 0);
        chk("rst_c_rvalid", 32'(c_rvalid), 0);
        chk("rst_d_rdata", d_rdata, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rstn = 1'b1;

        for (int i = 0; i < tbl.size(); i++)
            step(tbl[i]);

        // asynchronous reset while a C read return is in flight
        c_req = 1; c_we = 0; c_addr = 32'h60; c_ctrl = CCTL;
        d_req = 0; d_lock = 0;
        #1;
        chk("pre_c_gnt", 32'(c_gnt), 1);
        @(posedge clk);
        #1;
        chk("pre_c_rvalid", 32'(c_rvalid), 1);
        chk("pre_c_rdata", c_rdata, exp_rd(32'h60));
        d_req = 1; d_addr = 32'h64;
        rstn = 1'b0;
        #1;
        chk("mid_c_rvalid", 32'(c_rvalid), 0);
        chk("mid_c_rdata", c_rdata, 0);
        chk("mid_c_gnt", 32'(c_gnt), 0);
        chk("mid_d_gnt", 32'(d_gnt), 0);
        chk("mid_m_we", 32'(m_we), 0);
        chk("mid_m_addr", m_addr, 0);
        chk("mid_m_wdata", m_wdata, 0);
        chk("mid_d_rvalid", 32'(d_rvalid), 0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        c_last = '0;
        d_last = '0;
        cq.delete();
        dq.delete();
        step(mk(1, 0, 32'h68, 0, 1, 0, 0, 32'h6C, 0, G_C));
        step(mk(0, 0, 0, 0, 1, 0, 0, 32'h6C, 0, G_D));
        step(idle());

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
